// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and a parameter-legality helper used by every FIFO instance.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH_DEF = 8;
  localparam int FIFO_ADDR_WIDTH_DEF = 4;

  function automatic bit fifo_levels_ok(input int depth, input int ae_level, input int af_level);
    return (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo; master drives requests, slave is the FIFO.
interface param_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
);
  logic                  push;
  logic                  pop;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, err_clr, push_data,
    input  pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, err_clr, push_data,
    output pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read. Contents are not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Show-ahead parametrised FIFO with occupancy flags. Sticky overflow/underflow flags
// are built only when PARAM_FIFO_ERR_FLAGS_EN is defined; otherwise they read 0.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic          clk,
  input  logic          reset,
  param_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  if (!fifo_levels_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_levels
    $error("param_fifo: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CW-1:0]         count_q;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // A push into a full FIFO is still taken when a pop frees the head slot that cycle.
  assign push_ok = bus.push & (~full | bus.pop);
  assign pop_ok  = bus.pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) w_ptr <= w_ptr + 1'b1;
      if (pop_ok)  r_ptr <= r_ptr + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (w_ptr),
    .wr_data (bus.push_data),
    .rd_addr (r_ptr),
    .rd_data (bus.pop_data)
  );

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push & ~push_ok)  overflow_q <= 1'b1;
      else if (bus.err_clr)     overflow_q <= 1'b0;
      if (bus.pop & ~pop_ok)    underflow_q <= 1'b1;
      else if (bus.err_clr)     underflow_q <= 1'b0;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: vector table, directed corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_param_fifo;

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  param_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  param_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_q[$];
  bit model_ovf = 1'b0;
  bit model_udf = 1'b0;

  typedef struct {
    bit         push;
    bit         pop;
    bit         clr;
    logic [7:0] data;
    int         exp_count;
    logic [7:0] exp_head;
    bit         exp_udf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit q, input logic [7:0] d, input bit c);
    int  sz;
    bit  take_push;
    bit  take_pop;
    logic [7:0] dropped;
    sz        = model_q.size();
    take_push = p && ((sz < DEPTH) || q);
    take_pop  = q && (sz > 0);
    if (take_pop) dropped = model_q.pop_front();
    if (take_push) model_q.push_back(d);
    if (p && !take_push) model_ovf = 1'b1;
    else if (c)          model_ovf = 1'b0;
    if (q && !take_pop)  model_udf = 1'b1;
    else if (c)          model_udf = 1'b0;
  endtask

  task automatic check_model();
    int sz;
    sz = model_q.size();
    check("count", 32'(bus.count), 32'(sz));
    check("full", 32'(bus.full), 32'(sz == DEPTH));
    check("empty", 32'(bus.empty), 32'(sz == 0));
    check("almost_full", 32'(bus.almost_full), 32'(sz >= DEPTH - 2));
    check("almost_empty", 32'(bus.almost_empty), 32'(sz <= 2));
    check("overflow", 32'(bus.overflow), 32'(ERR_EN & model_ovf));
    check("underflow", 32'(bus.underflow), 32'(ERR_EN & model_udf));
    if (sz > 0) check("pop_data", 32'(bus.pop_data), 32'(model_q[0]));
  endtask

  task automatic cyc(input bit p, input bit q, input logic [7:0] d, input bit c);
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d;
    bus.err_clr   = c;
    @(posedge clk);
    model_step(p, q, d, c);
    #1;
    check_model();
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ae", 32'(bus.almost_empty), 32'd1);
    check("rst_af", 32'(bus.almost_full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_udf", 32'(bus.underflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0; bus.push_data = '0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 1, 8'hA1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'hB2, 2, 8'hA1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'hB2, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'hC3, 1, 8'hC3, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'hD4, 1, 8'hD4, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'hD4, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h55, 2, 8'hD4, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h66, 3, 8'hD4, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h55, 1'b0};

    // reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("init_count", 32'(bus.count), 32'd0);
    check("init_empty", 32'(bus.empty), 32'd1);
    check("init_full", 32'(bus.full), 32'd0);
    check("init_ae", 32'(bus.almost_empty), 32'd1);
    check("init_af", 32'(bus.almost_full), 32'd0);
    check("init_ovf", 32'(bus.overflow), 32'd0);
    check("init_udf", 32'(bus.underflow), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].push, vecs[i].pop, vecs[i].data, vecs[i].clr);
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_udf", i), 32'(bus.underflow), 32'(ERR_EN & vecs[i].exp_udf));
      if (vecs[i].exp_count > 0)
        check($sformatf("vec%0d_head", i), 32'(bus.pop_data), 32'(vecs[i].exp_head));
    end

    do_reset();

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      check($sformatf("fill_af%0d", i), 32'(bus.almost_full), 32'(i + 1 >= 14));
    end
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_head", 32'(bus.pop_data), 32'h00);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_data%0d", i), 32'(bus.pop_data), 32'(i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check($sformatf("drain_ae%0d", i), 32'(bus.almost_empty), 32'(15 - i <= 2));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);

    // refill, rejected push, clear, then push+pop at full
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 1'b0, 8'h77, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'(ERR_EN));
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    check("pp_full_count", 32'(bus.count), 32'd16);
    check("pp_full_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("aa_drain%0d", i), 32'(bus.pop_data), (i == 15) ? 32'hAA : 32'(8'h11 + i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end

    // underflow on empty, push+pop on empty, clear
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("udf_set", 32'(bus.underflow), 32'(ERR_EN));
    cyc(1'b1, 1'b1, 8'h5A, 1'b0);
    check("pp_empty_count", 32'(bus.count), 32'd1);
    check("pp_empty_udf", 32'(bus.underflow), 32'(ERR_EN));
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("udf_clr", 32'(bus.underflow), 32'd0);

    // same-cycle clear and new error: set wins
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    check("udf_set_wins", 32'(bus.underflow), 32'(ERR_EN));
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // steady-state streaming across pointer wrap at count 4
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
      check($sformatf("wrap_count%0d", i), 32'(bus.count), 32'd4);
      check($sformatf("wrap_flags%0d", i), 32'({bus.full, bus.empty}), 32'd0);
    end

    // reset mid-operation at count 7
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    check("pre_reset_count", 32'(bus.count), 32'd7);
    do_reset();

    // random traffic with slowly varying push/pop bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 65 : 35;
      cyc($urandom_range(99) < bias, $urandom_range(99) < 50, 8'($urandom), $urandom_range(99) < 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
